circuit_merger: RTL and testbench
=================================

CIRCUIT_MERGER -- requirements
Module: circuit_merger

Interface
REQ-001 SHALL have parameter NUM_POINTS, default 1000: number of junction points, minimum 3; IDX_W = $clog2(NUM_POINTS).
REQ-002 SHALL have parameter NUM_CONNS, default 1000: number of point pairs consumed before the result is computed.
REQ-003 SHALL have parameter RES_W, default 64: result width.
REQ-004 SHALL have clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have pointa_in  input  IDX_W  first point index of the pair.
REQ-007 SHALL have pointb_in  input  IDX_W  second point index of the pair.
REQ-008 SHALL have points_vld  input  1  pair valid.
REQ-009 SHALL have points_rdy  output  1  block accepts a pair this cycle.
REQ-010 SHALL have result  output  RES_W  product of the three largest circuit sizes.
REQ-011 SHALL have result_vld  output  1  result valid; held until reset.
REQ-012 SHALL have busy  output  1  high in every state except ACCEPT and DONE.

Function
REQ-013 SHALL keep label[NUM_POINTS] (IDX_W bits) and size[NUM_POINTS] (IDX_W+1 bits) arrays, plus a pair counter of $clog2(NUM_CONNS+1) bits.
REQ-014 SHALL use states INIT, ACCEPT, LOOKUP, RELABEL, TOPK, MULT and DONE.
REQ-015 SHALL, in INIT, write label[i]=i and size[i]=1 for i=0..NUM_POINTS-1, one entry per cycle (NUM_POINTS cycles), then go to ACCEPT.
REQ-016 SHALL drive points_rdy high only in ACCEPT; a transfer occurs when points_vld && points_rdy; pair counter +1 per transfer.
REQ-017 SHALL, in LOOKUP (1 cycle), register la=label[a], lb=label[b]; if la==lb (including a==b) the pair is skipped and the block returns to ACCEPT, else it goes to RELABEL.
REQ-018 SHALL, in RELABEL, scan i=0..NUM_POINTS-1 one entry per cycle, writing label[i]=la where label[i]==lb; on the last cycle it writes size[la]+=size[lb] and size[lb]=0.
REQ-019 SHALL, after LOOKUP or RELABEL completes, go to TOPK when pair counter == NUM_CONNS, else to ACCEPT.
REQ-020 SHALL, in TOPK, scan size[0..NUM_POINTS-1] over NUM_POINTS cycles keeping t1>=t2>=t3; a value equal to an existing entry inserts below it.
REQ-021 SHALL, in MULT (1 cycle), compute result = t1*t2*t3 zero-extended to RES_W, then enter DONE with result_vld=1.
REQ-022 SHALL produce result 0 when fewer than three non-empty circuits exist.
REQ-023 SHALL remain in DONE, with points_rdy=0 and result held, until rst.
REQ-024 SHALL ignore points_vld outside ACCEPT; an upstream holding vld through LOOKUP/RELABEL loses no pair.

Reset
REQ-025 SHALL, while rst is high, set state=INIT with scan index, pair counter, t1..t3 = 0, points_rdy=0, result=0, result_vld=0, and busy=1.
REQ-026 SHALL, on rst asserted in any state (including mid-RELABEL or mid-TOPK), abandon the operation and restart INIT on release; array contents are then rewritten by INIT.

Configuration
REQ-027 SHALL, with CIRCUIT_LAST_MERGE_EN defined, add outputs last_pointa (IDX_W), last_pointb (IDX_W) and last_vld (1), plus a circuit count initialised to NUM_POINTS and decremented per merge.
REQ-028 SHALL, with CIRCUIT_LAST_MERGE_EN defined, latch the pair when a merge brings the circuit count to 1 and set last_vld the cycle after RELABEL ends; these outputs are 0 in reset.
REQ-029 SHALL, without CIRCUIT_LAST_MERGE_EN, omit these ports and the counter; all other behaviour is identical.

Verification
REQ-030 SHALL pass a reset test: NUM_POINTS=8, release rst -> points_rdy=0 for exactly 8 cycles, then 1; result_vld=0.
REQ-031 SHALL pass a merge test: NUM_POINTS=8, NUM_CONNS=4, pairs (0,1),(1,2),(3,4),(0,2) -> last pair skipped, result=6 (3*2*1), result_vld=1.
REQ-032 SHALL pass a backpressure test: points_vld held high -> points_rdy low for 1 LOOKUP + NUM_POINTS RELABEL cycles per merging pair, and 1 cycle per skipped pair.
REQ-033 SHALL pass a tie test: NUM_POINTS=6, pairs (0,1),(2,3),(4,5) -> result=8.
REQ-034 SHALL pass a mid-operation reset test: rst pulsed during RELABEL -> INIT rerun, result_vld=0; a fresh sequence gives the correct result.
REQ-035 SHALL pass a last-merge test with CIRCUIT_LAST_MERGE_EN: NUM_POINTS=4, pairs (0,1),(2,3),(1,3),(0,2) -> last_pointa=1, last_pointb=3, last_vld=1; the fourth pair is skipped.

Source files
------------

// File: rtl/circuit_merger.sv
// Purpose: union-find style circuit merger; outputs the product of the three largest circuit sizes.
// Latency: NUM_POINTS init; 1 (skip) or 1+NUM_POINTS (merge) cycles per pair; NUM_POINTS+1 cycles for the result.
// Backpressure: points_rdy is high only in ACCEPT; a pair held valid elsewhere waits and is never lost.
//
// Ports: clk/rst (sync, active high); pointa_in/pointb_in/points_vld/points_rdy pair handshake;
//        result/result_vld final product (held until rst); busy high outside ACCEPT and DONE.
// Optional macro CIRCUIT_LAST_MERGE_EN adds last_pointa/last_pointb/last_vld: the pair that
//        brought the circuit count down to one.
module circuit_merger #(
   parameter  int NUM_POINTS = 1000,
   parameter  int NUM_CONNS  = 1000,
   parameter  int RES_W      = 64,
   localparam int IDX_W      = $clog2(NUM_POINTS),
   localparam int CNT_W      = $clog2(NUM_CONNS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] pointa_in,
   input  logic [IDX_W-1:0] pointb_in,
   input  logic             points_vld,
   output logic             points_rdy,
   output logic [RES_W-1:0] result,
   output logic             result_vld,
   output logic             busy
`ifdef CIRCUIT_LAST_MERGE_EN
   ,
   output logic [IDX_W-1:0] last_pointa,
   output logic [IDX_W-1:0] last_pointb,
   output logic             last_vld
`endif
);

   localparam int                PROD_W   = 3 * (IDX_W + 1);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_POINTS - 1);
   localparam logic [CNT_W-1:0]  CONNS_C  = CNT_W'(NUM_CONNS);

   typedef enum logic [2:0] {INIT, ACCEPT, LOOKUP, RELABEL, TOPK, MULT, DONE} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   a_q, a_d, b_q, b_d;
   logic [IDX_W-1:0]   la_q, la_d, lb_q, lb_d;
   logic [IDX_W:0]     t1_q, t1_d, t2_q, t2_d, t3_q, t3_d;
   logic [RES_W-1:0]   result_q, result_d;
   logic               result_vld_q, result_vld_d;

   // Storage arrays; written through explicit write ports computed below.
   logic [IDX_W-1:0]   label_q [NUM_POINTS];
   logic [IDX_W:0]     size_q  [NUM_POINTS];

   logic               label_we;
   logic [IDX_W-1:0]   label_wa, label_wd;
   logic               size_we0, size_we1;
   logic [IDX_W-1:0]   size_wa0, size_wa1;
   logic [IDX_W:0]     size_wd0, size_wd1;

   logic [IDX_W:0]     cur_size;
   logic [PROD_W-1:0]  prod;

`ifdef CIRCUIT_LAST_MERGE_EN
   logic [IDX_W:0]     circ_cnt_q, circ_cnt_d;
   logic [IDX_W-1:0]   last_a_q, last_a_d, last_b_q, last_b_d;
   logic               last_vld_q, last_vld_d;
`endif

   assign cur_size = size_q[idx_q];
   assign prod     = PROD_W'(t1_q) * PROD_W'(t2_q) * PROD_W'(t3_q);

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      a_d          = a_q;
      b_d          = b_q;
      la_d         = la_q;
      lb_d         = lb_q;
      t1_d         = t1_q;
      t2_d         = t2_q;
      t3_d         = t3_q;
      result_d     = result_q;
      result_vld_d = result_vld_q;
      label_we     = 1'b0;
      label_wa     = idx_q;
      label_wd     = la_q;
      size_we0     = 1'b0;
      size_wa0     = la_q;
      size_wd0     = '0;
      size_we1     = 1'b0;
      size_wa1     = lb_q;
      size_wd1     = '0;
`ifdef CIRCUIT_LAST_MERGE_EN
      circ_cnt_d   = circ_cnt_q;
      last_a_d     = last_a_q;
      last_b_d     = last_b_q;
      last_vld_d   = last_vld_q;
`endif
      unique case (state_q)
         INIT: begin
            label_we = 1'b1;
            label_wd = idx_q;
            size_we0 = 1'b1;
            size_wa0 = idx_q;
            size_wd0 = (IDX_W+1)'(1);
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               state_d = ACCEPT;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ACCEPT: begin
            if (points_vld) begin
               a_d     = pointa_in;
               b_d     = pointb_in;
               cnt_d   = cnt_q + 1'b1;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            la_d  = label_q[a_q];
            lb_d  = label_q[b_q];
            idx_d = '0;
            // Already in the same circuit (covers a==b): nothing to merge.
            if (label_q[a_q] == label_q[b_q])
               state_d = (cnt_q == CONNS_C) ? TOPK : ACCEPT;
            else
               state_d = RELABEL;
         end
         RELABEL: begin
            label_we = (label_q[idx_q] == lb_q);
            if (idx_q == LAST_IDX) begin
               // la != lb here, so the two size writes never collide.
               size_we0 = 1'b1;
               size_wd0 = size_q[la_q] + size_q[lb_q];
               size_we1 = 1'b1;
               idx_d    = '0;
               state_d  = (cnt_q == CONNS_C) ? TOPK : ACCEPT;
`ifdef CIRCUIT_LAST_MERGE_EN
               circ_cnt_d = circ_cnt_q - 1'b1;
               if (circ_cnt_q == (IDX_W+1)'(2)) begin
                  last_a_d   = a_q;
                  last_b_d   = b_q;
                  last_vld_d = 1'b1;
               end
`endif
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         TOPK: begin
            // Strict compares make an equal value land below the existing entry.
            if (cur_size > t1_q) begin
               t3_d = t2_q;
               t2_d = t1_q;
               t1_d = cur_size;
            end else if (cur_size > t2_q) begin
               t3_d = t2_q;
               t2_d = cur_size;
            end else if (cur_size > t3_q) begin
               t3_d = cur_size;
            end
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               state_d = MULT;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         MULT: begin
            result_d     = RES_W'(prod);
            result_vld_d = 1'b1;
            state_d      = DONE;
         end
         DONE: begin
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= INIT;
         idx_q        <= '0;
         cnt_q        <= '0;
         a_q          <= '0;
         b_q          <= '0;
         la_q         <= '0;
         lb_q         <= '0;
         t1_q         <= '0;
         t2_q         <= '0;
         t3_q         <= '0;
         result_q     <= '0;
         result_vld_q <= 1'b0;
`ifdef CIRCUIT_LAST_MERGE_EN
         circ_cnt_q   <= (IDX_W+1)'(NUM_POINTS);
         last_a_q     <= '0;
         last_b_q     <= '0;
         last_vld_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         a_q          <= a_d;
         b_q          <= b_d;
         la_q         <= la_d;
         lb_q         <= lb_d;
         t1_q         <= t1_d;
         t2_q         <= t2_d;
         t3_q         <= t3_d;
         result_q     <= result_d;
         result_vld_q <= result_vld_d;
`ifdef CIRCUIT_LAST_MERGE_EN
         circ_cnt_q   <= circ_cnt_d;
         last_a_q     <= last_a_d;
         last_b_q     <= last_b_d;
         last_vld_q   <= last_vld_d;
`endif
      end
   end

   // Arrays are not reset; INIT rewrites every entry after each reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (label_we) label_q[label_wa] <= label_wd;
         if (size_we0) size_q[size_wa0]  <= size_wd0;
         if (size_we1) size_q[size_wa1]  <= size_wd1;
      end
   end

   assign points_rdy = (state_q == ACCEPT) && !rst;
   assign busy       = rst || !((state_q == ACCEPT) || (state_q == DONE));
   assign result     = result_q;
   assign result_vld = result_vld_q;

`ifdef CIRCUIT_LAST_MERGE_EN
   assign last_pointa = last_a_q;
   assign last_pointb = last_b_q;
   assign last_vld    = last_vld_q;
`endif

endmodule

// File: tb/tb_circuit_merger.sv
module tb_circuit_merger;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [2:0]  pa, pb;
   logic        vld;
   int          sel;

   logic        rdy8, rv8, busy8;
   logic [63:0] res8;
   logic        rdy6, rv6, busy6;
   logic [63:0] res6;

   logic        cur_rdy, cur_rv, cur_busy;
   logic [63:0] cur_res;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];

   circuit_merger #(.NUM_POINTS(8), .NUM_CONNS(4), .RES_W(64)) u_dut8 (
      .clk(clk), .rst(rst), .pointa_in(pa), .pointb_in(pb),
      .points_vld(vld && (sel == 0)), .points_rdy(rdy8),
      .result(res8), .result_vld(rv8), .busy(busy8)
`ifdef CIRCUIT_LAST_MERGE_EN
      , .last_pointa(), .last_pointb(), .last_vld()
`endif
   );

   circuit_merger #(.NUM_POINTS(6), .NUM_CONNS(3), .RES_W(64)) u_dut6 (
      .clk(clk), .rst(rst), .pointa_in(pa), .pointb_in(pb),
      .points_vld(vld && (sel == 1)), .points_rdy(rdy6),
      .result(res6), .result_vld(rv6), .busy(busy6)
`ifdef CIRCUIT_LAST_MERGE_EN
      , .last_pointa(), .last_pointb(), .last_vld()
`endif
   );

`ifdef CIRCUIT_LAST_MERGE_EN
   logic        rdy4, rv4, busy4, lv4;
   logic [63:0] res4;
   logic [1:0]  lpa4, lpb4;
   circuit_merger #(.NUM_POINTS(4), .NUM_CONNS(4), .RES_W(64)) u_dut4 (
      .clk(clk), .rst(rst), .pointa_in(pa[1:0]), .pointb_in(pb[1:0]),
      .points_vld(vld && (sel == 2)), .points_rdy(rdy4),
      .result(res4), .result_vld(rv4), .busy(busy4),
      .last_pointa(lpa4), .last_pointb(lpb4), .last_vld(lv4)
   );
   always_comb begin
      cur_rdy  = (sel == 0) ? rdy8  : (sel == 1) ? rdy6  : rdy4;
      cur_rv   = (sel == 0) ? rv8   : (sel == 1) ? rv6   : rv4;
      cur_busy = (sel == 0) ? busy8 : (sel == 1) ? busy6 : busy4;
      cur_res  = (sel == 0) ? res8  : (sel == 1) ? res6  : res4;
   end
`else
   always_comb begin
      cur_rdy  = (sel == 0) ? rdy8  : rdy6;
      cur_rv   = (sel == 0) ? rv8   : rv6;
      cur_busy = (sel == 0) ? busy8 : busy6;
      cur_res  = (sel == 0) ? res8  : res6;
   end
`endif

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Hold reset a few cycles, check reset outputs, release just after a rising edge.
   task automatic do_reset(input string tag);
      rst = 1'b1;
      vld = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk({tag, "_rst_rdy"},  {63'd0, cur_rdy},  64'd0);
      chk({tag, "_rst_rv"},   {63'd0, cur_rv},   64'd0);
      chk({tag, "_rst_busy"}, {63'd0, cur_busy}, 64'd1);
      chk({tag, "_rst_res"},  cur_res,           64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Present a pair with vld held; count cycles points_rdy stays low before the transfer.
   task automatic send(input string tag, input int a, input int b, input int exp_wait);
      int waits;
      pa    = 3'(a);
      pb    = 3'(b);
      vld   = 1'b1;
      waits = 0;
      forever begin
         @(negedge clk);
         if (cur_rdy) break;
         waits++;
         if (waits > 50) break;
      end
      chk({tag, "_wait"}, 64'(waits), 64'(exp_wait));
      @(posedge clk);
      #1;
   endtask

   task automatic wait_result(input string tag);
      int n;
      logic [63:0] exp;
      vld = 1'b0;
      n   = 0;
      @(negedge clk);
      while (!cur_rv && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_rv"}, {63'd0, cur_rv}, 64'd1);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF;
      chk({tag, "_result"}, cur_res, exp);
      chk({tag, "_done_rdy"},  {63'd0, cur_rdy},  64'd0);
      chk({tag, "_done_busy"}, {63'd0, cur_busy}, 64'd0);
   endtask

   initial begin
      rst = 1'b1;
      vld = 1'b0;
      pa  = '0;
      pb  = '0;
      sel = 0;

      // Merge test: (0,2) is already joined and skipped; sizes 3,2,1.
      do_reset("merge");
      exp_q.push_back(64'd6);
      send("merge_p1", 0, 1, 8);
      send("merge_p2", 1, 2, 9);
      send("merge_p3", 3, 4, 9);
      send("merge_p4", 0, 2, 9);
      wait_result("merge");

      // Result held in DONE; vld ignored there.
      vld = 1'b1;
      repeat (5) @(negedge clk);
      chk("hold_result", cur_res, 64'd6);
      chk("hold_rv",     {63'd0, cur_rv},  64'd1);
      chk("hold_rdy",    {63'd0, cur_rdy}, 64'd0);
      vld = 1'b0;

      // Backpressure: a skipped pair stalls 1 cycle, a merge 1+8.
      do_reset("bp");
      exp_q.push_back(64'd8);
      send("bp_p1", 0, 1, 8);
      send("bp_p2", 1, 0, 9);
      send("bp_p3", 2, 3, 1);
      send("bp_p4", 4, 5, 9);
      wait_result("bp");

      // Mid-operation reset during RELABEL, then a fresh sequence.
      do_reset("mid");
      send("mid_p1", 0, 1, 8);
      vld = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_busy", {63'd0, cur_busy}, 64'd1);
      chk("mid_rdy",  {63'd0, cur_rdy},  64'd0);
      do_reset("mid2");
      exp_q.push_back(64'd6);
      send("mid2_p1", 0, 1, 8);
      send("mid2_p2", 1, 2, 9);
      send("mid2_p3", 3, 4, 9);
      send("mid2_p4", 0, 2, 9);
      wait_result("mid2");

      // Tie test: three circuits of size 2.
      sel = 1;
      do_reset("tie");
      exp_q.push_back(64'd8);
      send("tie_p1", 0, 1, 6);
      send("tie_p2", 2, 3, 7);
      send("tie_p3", 4, 5, 7);
      wait_result("tie");

`ifdef CIRCUIT_LAST_MERGE_EN
      // Last-merge: (1,3) joins everything; (0,2) then skipped; one circuit -> result 0.
      sel = 2;
      do_reset("last");
      chk("last_rst_vld", {63'd0, lv4}, 64'd0);
      exp_q.push_back(64'd0);
      send("last_p1", 0, 1, 4);
      send("last_p2", 2, 3, 5);
      send("last_p3", 1, 3, 5);
      chk("last_vld_early", {63'd0, lv4}, 64'd0);
      send("last_p4", 0, 2, 5);
      chk("last_vld", {63'd0, lv4}, 64'd1);
      chk("last_pa",  {62'd0, lpa4}, 64'd1);
      chk("last_pb",  {62'd0, lpb4}, 64'd3);
      wait_result("last");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
